fp_mult_arbiter: RTL and testbench
==================================

// Module: fp_mult_arbiter
// PURPOSE
//  Shares one pipelined fp_mult_top instance between N_REQ requesters.
//  Each cycle, round-robin arbitration picks at most one valid request and issues {a,b,rnd} to the multiplier.
//  A tag pipeline tracks the issuing requester, so each z/status is routed back MUL_LAT cycles later.
//  Sits between client FP units and the multiplier, beside the round_pkg/mult_pkg users.
// PARAMETERS
//  N_REQ    4  number of requesters, 2..8
//  MUL_LAT  4  cycles from mul_a/mul_b/mul_rnd update to matching mul_z/mul_status; must match fp_mult_top
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            synchronous, active-high reset
//  en           in   1            0: no new grants; in-flight ops still complete
//  req_valid    in   N_REQ        request i valid
//  req_ready    out  N_REQ        request i accepted this cycle (one-hot or 0)
//  req_a        in   N_REQ x 32   operand a per requester
//  req_b        in   N_REQ x 32   operand b per requester
//  req_rnd      in   N_REQ x 3    round_mode per requester
//  mul_a        out  32           registered operand to multiplier
//  mul_b        out  32           registered operand to multiplier
//  mul_rnd      out  3            registered rounding mode to multiplier
//  mul_z        in   32           multiplier result
//  mul_status   in   8            multiplier status flags
//  rsp_valid    out  N_REQ        one-hot result strobe, no backpressure
//  rsp_z        out  32           result, valid with rsp_valid
//  rsp_status   out  8            status, valid with rsp_valid
//  sticky_clr   in   N_REQ        clear sticky flags of requester i
//  sticky_stat  out  N_REQ x 8    accumulated status per requester
// BEHAVIOUR
//  - Reset: req_ready=0, mul_a=mul_b=0, mul_rnd=IEEE_near, rsp_valid=0, rsp_z=0, rsp_status=0.
//    Reset also clears the tag pipeline, sets the RR pointer to N_REQ-1 (requester 0 wins first), and clears sticky_stat.
//  - Arbitration is combinational. Candidates are requesters with req_valid=1 while en=1.
//    The winner is the first candidate after ptr, searching upward and wrapping.
//  - req_ready[winner]=1 and the winner's request is accepted in that cycle. ptr<=winner at that edge.
//  - With no candidate, ptr holds and mul_* hold their last values.
//  - Issue: on acceptance, mul_a/b/rnd are registered at edge E. tag_pipe[0]<={1,id} is set at the same edge.
//  - Tag pipe: MUL_LAT-1 stage shift register that advances every cycle. Idle cycles insert {0,x}.
//  - Response: combinational from the last tag stage and mul_z/mul_status, valid in cycle E+MUL_LAT.
//    rsp_valid[id]=1 with rsp_z=mul_z and rsp_status=mul_status.
//    When no tag is valid, rsp_valid=0 and rsp_z/rsp_status hold 0.
//  - Throughput: 1 op/cycle total. A single continuously valid requester is granted every cycle.
//  - Fairness: with all requesters valid, grants go 0,1,..,N_REQ-1,0. Max wait is N_REQ-1 cycles.
//  - en=0 mid-stream: req_ready=0 immediately. Ops already issued still deliver responses.
//  - Reset mid-operation: in-flight tags are dropped and no rsp_valid is produced for them.
//    Multiplier outputs during that window are ignored.
//  - A requester may drop req_valid without having been granted; there is no penalty.
// CONFIGURATION
//  - Macro FP_ARB_STICKY_STATUS_EN.
//  - Defined: at each rsp_valid[i], sticky_stat[i] |= rsp_status. sticky_clr[i] zeroes sticky_stat[i] at the next edge.
//    If a clear and an update coincide, the clear wins and that cycle's status is discarded.
//  - Undefined: sticky_stat is tied to 0 and sticky_clr is ignored; the ports remain in place.
// STRUCTURE
//  - Package fp_arb_pkg holds:
//    - localparam ID_W = $clog2(N_REQ) helper (function clog2_min1)
//    - typedef tag_t {logic vld; logic [ID_W-1:0] id;}
//    - typedef req_t {a,b,rnd}, where rnd uses round_pkg::round_mode
//  - Sub-module fp_arb_rr, the combinational round-robin picker: (req, ptr) -> (gnt one-hot, gnt_id, any).
//  - Top file holds the operand registers, tag pipe, response demux and sticky logic.
// TESTING
//  - Reset, then hold idle: all outputs 0 and mul_rnd=IEEE_near.
//    After rst is released, req_valid=0 still gives rsp_valid=0 indefinitely.
//  - Single op, MUL_LAT=4: req0 a=40400000, b=40000000, IEEE_near, accepted at cycle 1.
//    Expect rsp_valid=0001 and rsp_z=40C00000 at cycle 5, with no other rsp_valid in between.
//  - All four requesters valid for 8 cycles, each with a=3FC00000, b=3FC00000.
//    Grants go 0,1,2,3,0,1,2,3. The matching rsp_valid sequence starts 4 cycles later, every rsp_z=40100000.
//  - en dropped for 2 cycles during a full stream: req_ready=0 in both cycles.
//    The 4 in-flight results still arrive on consecutive cycles, followed by a 2-cycle rsp gap.
//  - Reset asserted 2 cycles after 3 issues: no rsp_valid for those ops.
//    After reset, req2 alone is granted first because ptr was reset.
//  - FP_ARB_STICKY_STATUS_EN: req1 issues 7f800000 x 00000000, an invalid op.
//    Then sticky_stat[1] holds the invalid bit until sticky_clr[1]=1, and reads 0 one cycle after the clear.

Source files
------------

// File: rtl/fp_arb_pkg.sv
// Shared types for the fp_mult_arbiter slice: tag/request records and the rounding-mode encoding.
package fp_arb_pkg;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tag ids are sized for the largest supported requester count so the types stay fixed-width.
    localparam int N_REQ_MAX = 8;
    localparam int ID_W      = clog2_min1(N_REQ_MAX);

    typedef enum logic [2:0] {
        IEEE_near        = 3'd0,
        IEEE_zero        = 3'd1,
        IEEE_pos_inf     = 3'd2,
        IEEE_neg_inf     = 3'd3,
        IEEE_near_up     = 3'd4,
        IEEE_near_maxmag = 3'd5
    } round_mode_t;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        round_mode_t rnd;
    } req_t;

endpackage

// File: rtl/fp_mult_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after ptr, searching upward with wrap.
import fp_arb_pkg::*;

module fp_arb_rr #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    int best_d_s;

    // Pick the candidate with the smallest rotated distance from ptr+1.
    always_comb begin
        best_d_s = N_REQ;
        gnt_id   = '0;
        any      = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            int d_v;
            d_v = j - int'(ptr) - 1;
            if (d_v < 0) begin
                d_v = d_v + N_REQ;
            end else begin
                d_v = d_v;
            end
            if (req[j] && (d_v < best_d_s)) begin
                best_d_s = d_v;
                gnt_id   = ID_W'(j);
                any      = 1'b1;
            end else begin
                best_d_s = best_d_s;
            end
        end
    end

    // Expand the winning id into a one-hot grant.
    always_comb begin
        gnt = '0;
        for (int j = 0; j < N_REQ; j++) begin
            gnt[j] = any && (gnt_id == ID_W'(j));
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined multiplier among N_REQ requesters with round-robin issue and tagged response routing.
// Optional feature macro: FP_ARB_STICKY_STATUS_EN (per-requester sticky status accumulation).
import fp_arb_pkg::*;

module fp_mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0][31:0] req_a,
    input  logic [N_REQ-1:0][31:0] req_b,
    input  logic [N_REQ-1:0][2:0]  req_rnd,
    output logic [31:0]            mul_a,
    output logic [31:0]            mul_b,
    output logic [2:0]             mul_rnd,
    input  logic [31:0]            mul_z,
    input  logic [7:0]             mul_status,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [31:0]            rsp_z,
    output logic [7:0]             rsp_status,
    input  logic [N_REQ-1:0]       sticky_clr,
    output logic [N_REQ-1:0][7:0]  sticky_stat
);

    localparam int SEL_W = clog2_min1(N_REQ);

    logic [N_REQ-1:0] cand_s;
    logic [N_REQ-1:0] gnt_s;
    logic [ID_W-1:0]  gnt_id_s;
    logic             any_s;
    logic [SEL_W-1:0] gnt_sel_s;
    logic [ID_W-1:0]  ptr_r;
    req_t             sel_req_s;
    req_t             mul_req_r;
    tag_t             tag_r [MUL_LAT];
    tag_t             tag_last_s;

    // Only present requests while enabled; en=0 blocks new grants at once.
    always_comb begin
        if (en) begin
            cand_s = req_valid;
        end else begin
            cand_s = '0;
        end
    end

    fp_arb_rr #(.N_REQ(N_REQ)) u_rr (
        .req    (cand_s),
        .ptr    (ptr_r),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s),
        .any    (any_s)
    );

    assign req_ready = gnt_s;
    assign gnt_sel_s = gnt_id_s[SEL_W-1:0];

    // Gather the winner's operands into one record.
    always_comb begin
        sel_req_s.a   = req_a[gnt_sel_s];
        sel_req_s.b   = req_b[gnt_sel_s];
        sel_req_s.rnd = round_mode_t'(req_rnd[gnt_sel_s]);
    end

    // The tag pipe is one load stage plus MUL_LAT-1 shift stages so the tag lines up with mul_z.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r     <= ID_W'(N_REQ - 1);
            mul_req_r <= '{a: 32'h0000_0000, b: 32'h0000_0000, rnd: IEEE_near};
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            if (any_s) begin
                ptr_r     <= gnt_id_s;
                mul_req_r <= sel_req_s;
            end else begin
                ptr_r     <= ptr_r;
                mul_req_r <= mul_req_r;
            end
            tag_r[0] <= '{vld: any_s, id: gnt_id_s};
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign mul_a      = mul_req_r.a;
    assign mul_b      = mul_req_r.b;
    assign mul_rnd    = mul_req_r.rnd;
    assign tag_last_s = tag_r[MUL_LAT-1];

    // Route the multiplier output to its owner; outputs read zero when no tag is live.
    always_comb begin
        rsp_valid = '0;
        if (tag_last_s.vld) begin
            rsp_valid[tag_last_s.id[SEL_W-1:0]] = 1'b1;
            rsp_z      = mul_z;
            rsp_status = mul_status;
        end else begin
            rsp_z      = 32'h0000_0000;
            rsp_status = 8'h00;
        end
    end

`ifdef FP_ARB_STICKY_STATUS_EN
    logic [N_REQ-1:0][7:0] sticky_r;

    // Accumulate status per requester; a clear beats a same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_r <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (sticky_clr[i]) begin
                    sticky_r[i] <= 8'h00;
                end else if (rsp_valid[i]) begin
                    sticky_r[i] <= sticky_r[i] | rsp_status;
                end else begin
                    sticky_r[i] <= sticky_r[i];
                end
            end
        end
    end

    assign sticky_stat = sticky_r;
`else
    logic unused_sticky_clr_s;

    assign unused_sticky_clr_s = ^sticky_clr;
    assign sticky_stat         = '0;
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter with a small pipelined multiplier model answering a fixed product table.
`timescale 1ns/1ps

module tb_fp_mult_arbiter;

    localparam int N_REQ   = 4;
    localparam int MUL_LAT = 4;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0][31:0] req_a;
    logic [N_REQ-1:0][31:0] req_b;
    logic [N_REQ-1:0][2:0]  req_rnd;
    logic [31:0]            mul_a;
    logic [31:0]            mul_b;
    logic [2:0]             mul_rnd;
    logic [31:0]            mul_z;
    logic [7:0]             mul_status;
    logic [N_REQ-1:0]       rsp_valid;
    logic [31:0]            rsp_z;
    logic [7:0]             rsp_status;
    logic [N_REQ-1:0]       sticky_clr;
    logic [N_REQ-1:0][7:0]  sticky_stat;

    int n_checks = 0;
    int n_errors = 0;

    fp_mult_arbiter #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_rnd     (req_rnd),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_rnd     (mul_rnd),
        .mul_z       (mul_z),
        .mul_status  (mul_status),
        .rsp_valid   (rsp_valid),
        .rsp_z       (rsp_z),
        .rsp_status  (rsp_status),
        .sticky_clr  (sticky_clr),
        .sticky_stat (sticky_stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: operands travel MUL_LAT-1 register stages, then a fixed product table.
    logic [31:0] pa [MUL_LAT-1];
    logic [31:0] pb [MUL_LAT-1];

    always_ff @(posedge clk) begin
        pa[0] <= mul_a;
        pb[0] <= mul_b;
        for (int i = 1; i < MUL_LAT - 1; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end

    function automatic logic [39:0] fmul_table(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h4040_0000, 32'h4000_0000}: return {8'h00, 32'h40C0_0000};
            {32'h3FC0_0000, 32'h3FC0_0000}: return {8'h00, 32'h4010_0000};
            {32'h7F80_0000, 32'h0000_0000}: return {8'h04, 32'h7FC0_0000};
            default:                        return 40'h0;
        endcase
    endfunction

    assign {mul_status, mul_z} = fmul_table(pa[MUL_LAT-2], pb[MUL_LAT-2]);

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        rst        = 1'b1;
        en         = 1'b1;
        req_valid  = '0;
        sticky_clr = '0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_all_ops(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i]   = a;
            req_b[i]   = b;
            req_rnd[i] = 3'd0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] one_v;
        logic [3:0] rdy4  [13] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [3:0] rsp4  [13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0};
        logic [3:0] val5  [10] = '{4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
        logic       rst5  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] rdy5  [10] = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [3:0] rsp5  [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4};
        logic [7:0] stk6  [8];
        one_v = 4'b0001;

        rst        = 1'b1;
        en         = 1'b1;
        req_valid  = '0;
        sticky_clr = '0;
        set_all_ops(32'h0, 32'h0);

        // Reset state.
        next_cycle();
        next_cycle();
        #1;
        check_val("rst_mul_a",      64'(mul_a),      64'h0);
        check_val("rst_mul_b",      64'(mul_b),      64'h0);
        check_val("rst_mul_rnd",    64'(mul_rnd),    64'h0);
        check_val("rst_rsp_valid",  64'(rsp_valid),  64'h0);
        check_val("rst_rsp_z",      64'(rsp_z),      64'h0);
        check_val("rst_rsp_status", 64'(rsp_status), 64'h0);
        check_val("rst_sticky",     64'(sticky_stat), 64'h0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            #1;
            check_val("idle_ready", 64'(req_ready), 64'h0);
            check_val("idle_rsp",   64'(rsp_valid), 64'h0);
        end

        // Single op from requester 0: 3.0 * 2.0 = 6.0, response 4 cycles after acceptance.
        req_a[0] = 32'h4040_0000;
        req_b[0] = 32'h4000_0000;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            req_valid = (c == 0) ? 4'b0001 : 4'b0000;
            #1;
            check_val("single_ready", 64'(req_ready), (c == 0) ? 64'h1 : 64'h0);
            check_val("single_rsp",   64'(rsp_valid), (c == 4) ? 64'h1 : 64'h0);
            check_val("single_z",     64'(rsp_z),     (c == 4) ? 64'h40C0_0000 : 64'h0);
            check_val("single_st",    64'(rsp_status), 64'h0);
            if (c == 1) begin
                check_val("single_mul_a", 64'(mul_a), 64'h4040_0000);
                check_val("single_mul_b", 64'(mul_b), 64'h4000_0000);
            end else begin
                check_val("single_mul_a_hold", 64'(mul_a), (c == 0) ? 64'h0 : 64'h4040_0000);
            end
        end

        // All four valid for 8 cycles: 1.5 * 1.5 = 2.25, strict rotation 0,1,2,3.
        do_reset();
        set_all_ops(32'h3FC0_0000, 32'h3FC0_0000);
        for (int c = 0; c < 13; c++) begin
            next_cycle();
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            check_val("rr_ready", 64'(req_ready), (c < 8) ? 64'(one_v << (c % 4)) : 64'h0);
            check_val("rr_rsp",   64'(rsp_valid), (c >= 4 && c < 12) ? 64'(one_v << ((c - 4) % 4)) : 64'h0);
            check_val("rr_z",     64'(rsp_z),     (c >= 4 && c < 12) ? 64'h4010_0000 : 64'h0);
        end

        // en low for two cycles mid-stream.
        do_reset();
        for (int c = 0; c < 13; c++) begin
            next_cycle();
            req_valid = (c < 8) ? 4'hF : 4'h0;
            en        = (c == 4 || c == 5) ? 1'b0 : 1'b1;
            #1;
            check_val("en_ready", 64'(req_ready), 64'(rdy4[c]));
            check_val("en_rsp",   64'(rsp_valid), 64'(rsp4[c]));
        end
        en = 1'b1;

        // Reset two cycles after three issues drops them; then req2 alone wins first.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            req_valid = val5[c];
            rst       = rst5[c];
            #1;
            check_val("mrst_ready", 64'(req_ready), 64'(rdy5[c]));
            check_val("mrst_rsp",   64'(rsp_valid), 64'(rsp5[c]));
            if (c == 9) begin
                check_val("mrst_z", 64'(rsp_z), 64'h4010_0000);
            end else begin
                check_val("mrst_z0", 64'(rsp_z), 64'h0);
            end
        end
        next_cycle();
        req_valid = 4'hF;
        #1;
        check_val("mrst_ptr_after", 64'(req_ready), 64'h8);

        // Invalid op (inf * 0) from requester 1 and its sticky flag.
        do_reset();
        req_a[1] = 32'h7F80_0000;
        req_b[1] = 32'h0000_0000;
`ifdef FP_ARB_STICKY_STATUS_EN
        stk6 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04, 8'h00};
`else
        stk6 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            req_valid  = (c == 0) ? 4'b0010 : 4'b0000;
            sticky_clr = (c == 6) ? 4'b0010 : 4'b0000;
            #1;
            check_val("inv_ready",  64'(req_ready),  (c == 0) ? 64'h2 : 64'h0);
            check_val("inv_rsp",    64'(rsp_valid),  (c == 4) ? 64'h2 : 64'h0);
            check_val("inv_status", 64'(rsp_status), (c == 4) ? 64'h04 : 64'h0);
            check_val("inv_z",      64'(rsp_z),      (c == 4) ? 64'h7FC0_0000 : 64'h0);
            check_val("sticky1",    64'(sticky_stat[1]), 64'(stk6[c]));
            check_val("sticky0",    64'(sticky_stat[0]), 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
